tm1637_frame_sequencer: RTL

Sequences complete TM1637 display refreshes over the byte-level TM1637/DIO transmitter: data-command frame, address + segment-data frame, display-control frame. Snapshots a digit buffer and brightness on request, issues START/BYTE/STOP operations through a valid/ready/done handshake, and reports completion and ACK errors. Sits between the step ROM / application logic and the DIO-mode transmitter that drives tm1637_clk/tm1637_dio.

---
 rtl/tm1637_frame_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/tm1637_frame_sequencer.sv
// tm1637_frame_sequencer: runs one full TM1637 refresh (data command,
// address + segment data, display control) as START/BYTE/STOP operations
// offered to the byte-level DIO transmitter over valid/ready/done.
module tm1637_frame_sequencer #(
  parameter int          NUM_DIGITS     = 4,
  parameter logic [23:0] REFRESH_PERIOD = 24'd0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] digit_data,
  input  logic [2:0]              brightness,
  input  logic                    display_on,
  input  logic                    update,
  output logic                    busy,
  output logic                    done,
  output logic                    ack_err,
  output logic [1:0]              phy_cmd,
  output logic [7:0]              phy_data,
  output logic                    phy_valid,
  input  logic                    phy_ready,
  input  logic                    phy_done,
  input  logic                    phy_nak
);
  typedef enum logic [3:0] {
    IDLE, F1_START, F1_CMD, F1_STOP, F2_START, F2_ADDR, F2_DATA, F2_STOP,
    F3_START, F3_CTRL, F3_STOP, DONE
  } state_t;

  localparam logic [1:0] CMD_BYTE  = 2'b00;
  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;
  localparam logic [2:0] LAST_IDX  = 3'(NUM_DIGITS - 1);

  state_t                     state, nxt_state;
  logic                       waiting;        // 0 = offering op, 1 = waiting for phy_done
  logic [2:0]                 idx, nxt_idx;
  logic [NUM_DIGITS-1:0][7:0] digits_q;
  logic [7:0][7:0]            digit_tbl;
  logic [2:0]                 bright_q;
  logic                       on_q;
  logic                       pending;
  logic [23:0]                rf_cnt;
  logic                       rf_tick, start, is_byte;
  logic [1:0]                 nxt_cmd;
  logic [7:0]                 nxt_data;

  // Pad the snapshot to 8 entries so the 3-bit index never selects past it
  for (genvar g = 0; g < 8; g++) begin : g_tbl
    if (g < NUM_DIGITS) begin : g_real
      assign digit_tbl[g] = digits_q[g];
    end else begin : g_pad
      assign digit_tbl[g] = 8'h00;
    end
  end

  assign rf_tick = (REFRESH_PERIOD != 24'd0) && (rf_cnt == REFRESH_PERIOD - 24'd1);
  assign start   = (state == IDLE) && (update || pending || rf_tick);

  // Successor of the current op once its phy_done arrives, plus that op's cmd/byte
  always_comb begin
    is_byte   = (state == F1_CMD) || (state == F2_ADDR) ||
                (state == F2_DATA) || (state == F3_CTRL);
    nxt_state = state;
    nxt_idx   = idx;
    case (state)
      F1_START: nxt_state = F1_CMD;
      F1_CMD:   nxt_state = F1_STOP;
      F1_STOP:  nxt_state = ack_err ? DONE : F2_START;
      F2_START: nxt_state = F2_ADDR;
      F2_ADDR: begin
        nxt_state = phy_nak ? F2_STOP : F2_DATA;
        nxt_idx   = 3'd0;
      end
      F2_DATA: begin
        if (phy_nak || idx == LAST_IDX) nxt_state = F2_STOP;
        else                            nxt_idx   = idx + 3'd1;
      end
      F2_STOP:  nxt_state = ack_err ? DONE : F3_START;
      F3_START: nxt_state = F3_CTRL;
      F3_CTRL:  nxt_state = F3_STOP;
      F3_STOP:  nxt_state = DONE;
      default:  nxt_state = state;
    endcase

    nxt_cmd  = CMD_BYTE;
    nxt_data = 8'h00;
    case (nxt_state)
      F1_START, F2_START, F3_START: nxt_cmd = CMD_START;
      F1_STOP, F2_STOP, F3_STOP:    nxt_cmd = CMD_STOP;
      F1_CMD:  nxt_data = 8'h40;
      F2_ADDR: nxt_data = 8'hC0;
      F2_DATA: nxt_data = digit_tbl[nxt_idx];
      F3_CTRL: nxt_data = on_q ? {5'b10001, bright_q} : 8'h80;
      default: nxt_data = 8'h00;
    endcase
  end

  // Refresh FSM: ISSUE/WAIT handshake per op, snapshot, pending and auto-refresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      waiting   <= 1'b0;
      idx       <= 3'd0;
      digits_q  <= '0;
      bright_q  <= 3'd0;
      on_q      <= 1'b0;
      pending   <= 1'b0;
      rf_cnt    <= 24'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ack_err   <= 1'b0;
      phy_cmd   <= CMD_BYTE;
      phy_data  <= 8'h00;
      phy_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      if (update && state != IDLE) pending <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            digits_q  <= digit_data;
            bright_q  <= brightness;
            on_q      <= display_on;
            ack_err   <= 1'b0;
            pending   <= 1'b0;
            rf_cnt    <= 24'd0;
            idx       <= 3'd0;
            waiting   <= 1'b0;
            state     <= F1_START;
            busy      <= 1'b1;
            phy_valid <= 1'b1;
            phy_cmd   <= CMD_START;
            phy_data  <= 8'h00;
          end else begin
            rf_cnt <= rf_cnt + 24'd1;
          end
        end
        DONE: state <= IDLE;
        default: begin
          if (!waiting) begin
            if (phy_valid && phy_ready) begin
              phy_valid <= 1'b0;
              waiting   <= 1'b1;
            end
          end else if (phy_done) begin
            waiting  <= 1'b0;
            state    <= nxt_state;
            idx      <= nxt_idx;
            phy_cmd  <= nxt_cmd;
            phy_data <= nxt_data;
            if (is_byte && phy_nak) ack_err <= 1'b1;
            if (nxt_state == DONE) begin
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              phy_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end
endmodule
